// File: rtl/puf_response_sequencer.sv
// -----------------------------------------------------------------------------
// puf_response_sequencer
//
// Purpose:
//   Sequences the RO-PUF oscillator/mux/counter datapath to build one response
//   word. For each response bit it selects a pair of ring-oscillator paths,
//   clears the counters, enables the oscillators for a fixed window, waits for
//   the counters to settle and then compares them. The bits are packed into a
//   response word that is published together with a one-cycle done strobe.
//
// Parameters:
//   N_BITS  response bits per run (1..32)
//   WINDOW  cycles ro_en is held high per bit (>=1)
//   SETTLE  cycles after ro_en falls before the counts are sampled (>=1)
//   CW      width of count_a / count_b
//
// Ports:
//   clk             system clock
//   reset           synchronous reset, active-high
//   start           run request, accepted only while idle
//   challenge_base  base challenge, captured when start is accepted
//   count_a/count_b RO counter values, stable while ro_en is low
//   sel_a/sel_b     mux selects for the A and B counter paths
//   ro_en           oscillator enable
//   cnt_clr         counter clear, one-cycle pulse per bit
//   busy            high in every state except idle
//   done            one-cycle pulse, response valid in the same cycle
//   response        last completed response, held until the next done
//   ties            equal-count compares in the last run, saturating at 15
// -----------------------------------------------------------------------------
module puf_response_sequencer #(
   parameter int N_BITS = 8,
   parameter int WINDOW = 64,
   parameter int SETTLE = 4,
   parameter int CW     = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [4:0]        challenge_base,
   input  logic [CW-1:0]     count_a,
   input  logic [CW-1:0]     count_b,
   output logic [4:0]        sel_a,
   output logic [4:0]        sel_b,
   output logic              ro_en,
   output logic              cnt_clr,
   output logic              busy,
   output logic              done,
   output logic [N_BITS-1:0] response,
   output logic [3:0]        ties
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_RUN    = 3'd2,
      S_SETTLE = 3'd3,
      S_SAMPLE = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   // Phase counter is shared by RUN and SETTLE, so it is sized for the longer one.
   localparam int PW = (WINDOW > SETTLE) ? ($clog2(WINDOW) + 1) : ($clog2(SETTLE) + 1);
   localparam logic [PW-1:0] WIN_LAST = PW'(WINDOW - 1);
   localparam logic [PW-1:0] SET_LAST = PW'(SETTLE - 1);
   localparam logic [4:0]    IDX_LAST = 5'(N_BITS - 1);

   state_t              state_q, state_d;
   logic [PW-1:0]       phase_q, phase_d;
   logic [4:0]          idx_q, idx_d;
   logic [4:0]          base_q, base_d;
   logic [N_BITS-1:0]   bits_q, bits_d;
   logic [3:0]          ties_q, ties_d;
   logic [4:0]          sel_a_q, sel_a_d;
   logic [4:0]          sel_b_q, sel_b_d;
   logic                ro_en_q, ro_en_d;
   logic                cnt_clr_q, cnt_clr_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [N_BITS-1:0]   response_q, response_d;
   logic [4:0]          sel_off;

   // State and datapath registers; synchronous reset aborts any run at once.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         phase_q    <= '0;
         idx_q      <= 5'd0;
         base_q     <= 5'd0;
         bits_q     <= '0;
         ties_q     <= 4'd0;
         sel_a_q    <= 5'd0;
         sel_b_q    <= 5'd0;
         ro_en_q    <= 1'b0;
         cnt_clr_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         response_q <= '0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         idx_q      <= idx_d;
         base_q     <= base_d;
         bits_q     <= bits_d;
         ties_q     <= ties_d;
         sel_a_q    <= sel_a_d;
         sel_b_q    <= sel_b_d;
         ro_en_q    <= ro_en_d;
         cnt_clr_q  <= cnt_clr_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         response_q <= response_d;
      end
   end

   // Next-state logic plus bit index, phase counter, compare result and tie count.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      idx_d   = idx_q;
      base_d  = base_q;
      bits_d  = bits_q;
      ties_d  = ties_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_CLEAR;
               base_d  = challenge_base;
               idx_d   = 5'd0;
               ties_d  = 4'd0;
               bits_d  = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CLEAR: begin
            state_d = S_RUN;
            phase_d = '0;
         end
         S_RUN: begin
            if (phase_q == WIN_LAST) begin
               state_d = S_SETTLE;
               phase_d = '0;
            end else begin
               phase_d = phase_q + PW'(1'b1);
            end
         end
         S_SETTLE: begin
            if (phase_q == SET_LAST) begin
               state_d = S_SAMPLE;
               phase_d = '0;
            end else begin
               phase_d = phase_q + PW'(1'b1);
            end
         end
         S_SAMPLE: begin
            // Unsigned compare; an equal pair yields 0 and is counted as a tie.
            bits_d = bits_q | (N_BITS'(count_a > count_b) << idx_q);
            if ((count_a == count_b) && (ties_q != 4'd15)) begin
               ties_d = ties_q + 4'd1;
            end else begin
               ties_d = ties_q;
            end
            if (idx_q == IDX_LAST) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + 5'd1;
               state_d = S_CLEAR;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode from the next state so every output comes straight from a flop.
   always_comb begin
      sel_off   = 5'({idx_d, 1'b0});
      busy_d    = (state_d != S_IDLE);
      done_d    = (state_d == S_DONE);
      ro_en_d   = (state_d == S_RUN);
      cnt_clr_d = (state_d == S_CLEAR);
      if (state_d == S_CLEAR) begin
         // 5-bit adds wrap the challenge modulo 32.
         sel_a_d = base_d + sel_off;
         sel_b_d = base_d + sel_off + 5'd1;
      end else begin
         sel_a_d = sel_a_q;
         sel_b_d = sel_b_q;
      end
      if (state_d == S_DONE) begin
         response_d = bits_d;
      end else begin
         response_d = response_q;
      end
   end

   assign sel_a    = sel_a_q;
   assign sel_b    = sel_b_q;
   assign ro_en    = ro_en_q;
   assign cnt_clr  = cnt_clr_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign response = response_q;
   assign ties     = ties_q;

endmodule

// File: tb/tb_puf_response_sequencer.sv
// -----------------------------------------------------------------------------
// tb_puf_response_sequencer
//
// Self-checking bench for puf_response_sequencer. The bench plays the RO
// counters: it drives planned count pairs per bit and compares the observed
// timing, selects, response and tie count against a plain reference model.
// A second, 20-bit instance exercises the saturating tie counter.
// -----------------------------------------------------------------------------
module tb_puf_response_sequencer;

   localparam int NB      = 4;
   localparam int WIN     = 4;
   localparam int SET     = 2;
   localparam int PER_BIT = WIN + SET + 2;
   localparam int LAT     = NB * PER_BIT + 1;
   localparam int NB2     = 20;
   localparam int LAT2    = NB2 * (1 + 1 + 2) + 1;

   logic clk = 1'b0;
   logic reset, start, start2;
   logic [4:0] challenge_base, challenge_base2;
   logic [7:0] count_a, count_b, count_a2, count_b2;
   logic [4:0] sel_a, sel_b, sel_a2, sel_b2;
   logic ro_en, cnt_clr, busy, done;
   logic ro_en2, cnt_clr2, busy2, done2;
   logic [NB-1:0]  response;
   logic [NB2-1:0] response2;
   logic [3:0] ties, ties2;

   int nvec = 0;
   int nerr = 0;

   logic [7:0] plan_a [32];
   logic [7:0] plan_b [32];

   int         obs_done_cyc, obs_done_cnt, obs_clr_n, obs_both, obs_unstable, obs_busy_gap;
   int         obs_ro_n [32];
   logic [4:0] obs_sel_a [32];
   logic [4:0] obs_sel_b [32];
   logic [NB-1:0] obs_resp, obs_rst_resp;
   logic [3:0] obs_ties;
   logic obs_busy1, obs_after_busy, obs_after2_busy, obs_after2_clr;
   logic obs_rst_ro, obs_rst_busy, obs_rst_done;

   always #5 clk = ~clk;

   puf_response_sequencer #(.N_BITS(NB), .WINDOW(WIN), .SETTLE(SET), .CW(8)) dut (
      .clk(clk), .reset(reset), .start(start), .challenge_base(challenge_base),
      .count_a(count_a), .count_b(count_b), .sel_a(sel_a), .sel_b(sel_b),
      .ro_en(ro_en), .cnt_clr(cnt_clr), .busy(busy), .done(done),
      .response(response), .ties(ties)
   );

   puf_response_sequencer #(.N_BITS(NB2), .WINDOW(1), .SETTLE(1), .CW(8)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .challenge_base(challenge_base2),
      .count_a(count_a2), .count_b(count_b2), .sel_a(sel_a2), .sel_b(sel_b2),
      .ro_en(ro_en2), .cnt_clr(cnt_clr2), .busy(busy2), .done(done2),
      .response(response2), .ties(ties2)
   );

   // Reference model: bit k is 1 when planned A count beats planned B count.
   function automatic logic [NB-1:0] model_resp();
      int acc = 0;
      for (int k = 0; k < NB; k++) if (plan_a[k] > plan_b[k]) acc += (1 << k);
      return NB'(acc);
   endfunction

   // Reference model: equal pairs in the run, capped at 15.
   function automatic logic [3:0] model_ties();
      int c = 0;
      for (int k = 0; k < NB; k++) if (plan_a[k] == plan_b[k]) c++;
      return 4'((c > 15) ? 15 : c);
   endfunction

   function automatic logic [4:0] model_sel(input logic [4:0] base, input int k, input int side);
      int v;
      v = (int'(base) + 2 * k + side) % 32;
      return 5'(v);
   endfunction

   // Drive one run on dut and record observations (no checking here).
   task automatic do_run(input logic [4:0] base, input bit hold, input int poke_cyc,
                         input int rst_cyc, input int ncyc);
      int bitno;
      bitno = -1;
      obs_done_cyc = -1; obs_done_cnt = 0; obs_clr_n = 0; obs_both = 0;
      obs_unstable = 0; obs_busy_gap = 0; obs_resp = '0; obs_ties = 4'd0;
      obs_busy1 = 1'b0; obs_after_busy = 1'b1; obs_after2_busy = 1'b0; obs_after2_clr = 1'b0;
      obs_rst_ro = 1'b1; obs_rst_busy = 1'b1; obs_rst_done = 1'b1; obs_rst_resp = '1;
      for (int k = 0; k < 32; k++) begin
         obs_ro_n[k] = 0; obs_sel_a[k] = 5'd0; obs_sel_b[k] = 5'd0;
      end
      @(negedge clk);
      challenge_base = base;
      start = 1'b1;
      for (int cyc = 1; cyc <= ncyc; cyc++) begin
         @(negedge clk);
         start = (cyc == poke_cyc) ? 1'b1 : hold;
         if (cyc == 1) obs_busy1 = busy;
         if (ro_en && cnt_clr) obs_both++;
         if (cnt_clr) begin
            bitno++;
            obs_clr_n++;
            if (bitno >= 0 && bitno < 32) begin
               obs_sel_a[bitno] = sel_a;
               obs_sel_b[bitno] = sel_b;
            end
            count_a = 8'd0;
            count_b = 8'd0;
         end else if (ro_en) begin
            if (bitno >= 0 && bitno < 32) begin
               obs_ro_n[bitno]++;
               if (sel_a != obs_sel_a[bitno] || sel_b != obs_sel_b[bitno]) obs_unstable++;
            end
            count_a = 8'($urandom);
            count_b = 8'($urandom);
         end else if (busy && bitno >= 0 && bitno < 32) begin
            count_a = plan_a[bitno];
            count_b = plan_b[bitno];
         end
         if (obs_done_cyc < 0 && rst_cyc < 0 && !busy) obs_busy_gap++;
         if (done) begin
            obs_done_cnt++;
            if (obs_done_cyc < 0) begin
               obs_done_cyc = cyc;
               obs_resp = response;
               obs_ties = ties;
            end
         end
         if (obs_done_cyc > 0 && cyc == obs_done_cyc + 1) obs_after_busy = busy;
         if (obs_done_cyc > 0 && cyc == obs_done_cyc + 2) begin
            obs_after2_busy = busy;
            obs_after2_clr  = cnt_clr;
         end
         if (cyc == rst_cyc) reset = 1'b1;
         if (rst_cyc > 0 && cyc == rst_cyc + 1) begin
            obs_rst_ro   = ro_en;
            obs_rst_busy = busy;
            obs_rst_done = done;
            obs_rst_resp = response;
            reset = 1'b0;
         end
      end
      start = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; start2 = 1'b0;
      challenge_base = 5'd0; challenge_base2 = 5'd0;
      count_a = 8'd0; count_b = 8'd0; count_a2 = 8'h5a; count_b2 = 8'h5a;
      repeat (3) @(posedge clk);
      @(negedge clk);
      nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got=%b exp=0", busy); end
      nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done got=%b exp=0", done); end
      nvec++; if (ro_en !== 1'b0) begin nerr++; $display("FAIL reset_ro_en got=%b exp=0", ro_en); end
      nvec++; if (cnt_clr !== 1'b0) begin nerr++; $display("FAIL reset_cnt_clr got=%b exp=0", cnt_clr); end
      nvec++; if (sel_a !== 5'd0 || sel_b !== 5'd0) begin nerr++; $display("FAIL reset_sel got=%0d,%0d exp=0,0", sel_a, sel_b); end
      nvec++; if (response !== '0) begin nerr++; $display("FAIL reset_response got=%b exp=0", response); end
      nvec++; if (ties !== 4'd0) begin nerr++; $display("FAIL reset_ties got=%0d exp=0", ties); end
      nvec++; if (busy2 !== 1'b0 || ties2 !== 4'd0) begin nerr++; $display("FAIL reset_dut2 got busy=%b ties=%0d exp=0,0", busy2, ties2); end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      for (int k = 0; k < NB; k++) begin plan_a[k] = 8'($urandom); plan_b[k] = 8'($urandom); end
      do_run(5'd0, 1'b0, -1, -1, LAT + 4);
      nvec++; if (obs_busy1 !== 1'b1) begin nerr++; $display("FAIL basic_busy_rise got=%b exp=1", obs_busy1); end
      nvec++; if (obs_done_cyc != LAT) begin nerr++; $display("FAIL basic_done_latency got=%0d exp=%0d", obs_done_cyc, LAT); end
      nvec++; if (obs_done_cnt != 1) begin nerr++; $display("FAIL basic_done_count got=%0d exp=1", obs_done_cnt); end
      nvec++; if (obs_resp !== model_resp()) begin nerr++; $display("FAIL basic_response got=%b exp=%b", obs_resp, model_resp()); end
      nvec++; if (obs_ties !== model_ties()) begin nerr++; $display("FAIL basic_ties got=%0d exp=%0d", obs_ties, model_ties()); end
      for (int k = 0; k < NB; k++) begin
         nvec++;
         if (obs_sel_a[k] !== model_sel(5'd0, k, 0) || obs_sel_b[k] !== model_sel(5'd0, k, 1)) begin
            nerr++;
            $display("FAIL basic_sel bit%0d got=(%0d,%0d) exp=(%0d,%0d)", k, obs_sel_a[k], obs_sel_b[k], model_sel(5'd0, k, 0), model_sel(5'd0, k, 1));
         end
      end
      nvec++; if (obs_busy_gap != 0) begin nerr++; $display("FAIL basic_busy_gap got=%0d exp=0", obs_busy_gap); end
      nvec++; if (obs_after_busy !== 1'b0) begin nerr++; $display("FAIL basic_idle_after_done got=%b exp=0", obs_after_busy); end
   endtask

   task automatic test_pattern();
      for (int k = 0; k < NB; k++) begin
         if (k % 2 == 0) begin plan_a[k] = 8'($urandom_range(129, 255)); plan_b[k] = 8'($urandom_range(0, 128)); end
         else begin plan_a[k] = 8'($urandom_range(0, 128)); plan_b[k] = 8'($urandom_range(129, 255)); end
      end
      do_run(5'($urandom_range(0, 31)), 1'b0, -1, -1, LAT + 2);
      nvec++; if (obs_resp !== 4'b0101) begin nerr++; $display("FAIL pattern_response got=%b exp=0101", obs_resp); end
      nvec++; if (obs_ties !== 4'd0) begin nerr++; $display("FAIL pattern_ties got=%0d exp=0", obs_ties); end
      nvec++; if (response !== 4'b0101) begin nerr++; $display("FAIL pattern_held got=%b exp=0101", response); end
   endtask

   task automatic test_wrap();
      for (int k = 0; k < NB; k++) begin plan_a[k] = 8'($urandom); plan_b[k] = 8'($urandom); end
      do_run(5'd31, 1'b0, -1, -1, LAT + 2);
      nvec++; if (obs_sel_a[0] !== 5'd31 || obs_sel_b[0] !== 5'd0) begin nerr++; $display("FAIL wrap_pair0 got=(%0d,%0d) exp=(31,0)", obs_sel_a[0], obs_sel_b[0]); end
      nvec++; if (obs_sel_a[1] !== 5'd1 || obs_sel_b[1] !== 5'd2) begin nerr++; $display("FAIL wrap_pair1 got=(%0d,%0d) exp=(1,2)", obs_sel_a[1], obs_sel_b[1]); end
      nvec++; if (obs_resp !== model_resp()) begin nerr++; $display("FAIL wrap_response got=%b exp=%b", obs_resp, model_resp()); end
   endtask

   task automatic test_ties();
      for (int k = 0; k < NB; k++) begin plan_a[k] = 8'($urandom); plan_b[k] = plan_a[k]; end
      do_run(5'($urandom_range(0, 31)), 1'b0, -1, -1, LAT + 2);
      nvec++; if (obs_resp !== 4'b0000) begin nerr++; $display("FAIL ties_response got=%b exp=0000", obs_resp); end
      nvec++; if (obs_ties !== 4'd4) begin nerr++; $display("FAIL ties_count got=%0d exp=4", obs_ties); end
   endtask

   task automatic test_timing();
      logic [4:0] base;
      for (int it = 0; it < 6; it++) begin
         base = 5'($urandom_range(0, 31));
         for (int k = 0; k < NB; k++) begin plan_a[k] = 8'($urandom_range(0, 3)); plan_b[k] = 8'($urandom_range(0, 3)); end
         do_run(base, 1'b0, -1, -1, LAT + 2);
         nvec++; if (obs_done_cyc != LAT) begin nerr++; $display("FAIL timing_latency it%0d got=%0d exp=%0d", it, obs_done_cyc, LAT); end
         nvec++; if (obs_resp !== model_resp()) begin nerr++; $display("FAIL timing_response it%0d got=%b exp=%b", it, obs_resp, model_resp()); end
         nvec++; if (obs_ties !== model_ties()) begin nerr++; $display("FAIL timing_ties it%0d got=%0d exp=%0d", it, obs_ties, model_ties()); end
         nvec++; if (obs_clr_n != NB) begin nerr++; $display("FAIL timing_clr_pulses it%0d got=%0d exp=%0d", it, obs_clr_n, NB); end
         nvec++; if (obs_both != 0) begin nerr++; $display("FAIL timing_overlap it%0d got=%0d exp=0", it, obs_both); end
         nvec++; if (obs_unstable != 0) begin nerr++; $display("FAIL timing_sel_stable it%0d got=%0d exp=0", it, obs_unstable); end
         for (int k = 0; k < NB; k++) begin
            nvec++; if (obs_ro_n[k] != WIN) begin nerr++; $display("FAIL timing_ro_window it%0d bit%0d got=%0d exp=%0d", it, k, obs_ro_n[k], WIN); end
            nvec++;
            if (obs_sel_a[k] !== model_sel(base, k, 0) || obs_sel_b[k] !== model_sel(base, k, 1)) begin
               nerr++;
               $display("FAIL timing_sel it%0d bit%0d got=(%0d,%0d) exp=(%0d,%0d)", it, k, obs_sel_a[k], obs_sel_b[k], model_sel(base, k, 0), model_sel(base, k, 1));
            end
         end
      end
   endtask

   task automatic test_start_ignored();
      for (int k = 0; k < NB; k++) begin plan_a[k] = 8'($urandom); plan_b[k] = 8'($urandom); end
      do_run(5'd9, 1'b0, 3, -1, LAT + 6);
      nvec++; if (obs_done_cnt != 1) begin nerr++; $display("FAIL ignore_done_count got=%0d exp=1", obs_done_cnt); end
      nvec++; if (obs_done_cyc != LAT) begin nerr++; $display("FAIL ignore_latency got=%0d exp=%0d", obs_done_cyc, LAT); end
      nvec++; if (obs_after_busy !== 1'b0 || obs_after2_busy !== 1'b0) begin nerr++; $display("FAIL ignore_not_queued got=%b%b exp=00", obs_after_busy, obs_after2_busy); end
   endtask

   task automatic test_reset_mid();
      pulse_reset();
      for (int k = 0; k < NB; k++) begin plan_a[k] = 8'd200; plan_b[k] = 8'd10; end
      do_run(5'd4, 1'b0, -1, 6, LAT + 4);
      nvec++; if (obs_rst_ro !== 1'b0 || obs_rst_busy !== 1'b0) begin nerr++; $display("FAIL midreset_settle got ro_en=%b busy=%b exp=0,0", obs_rst_ro, obs_rst_busy); end
      nvec++; if (obs_rst_resp !== '0) begin nerr++; $display("FAIL midreset_response got=%b exp=0000", obs_rst_resp); end
      nvec++; if (obs_done_cnt != 0) begin nerr++; $display("FAIL midreset_no_done got=%0d exp=0", obs_done_cnt); end
      nvec++; if (response !== '0) begin nerr++; $display("FAIL midreset_response_end got=%b exp=0000", response); end
      do_run(5'd4, 1'b0, -1, 3, LAT + 4);
      nvec++; if (obs_rst_ro !== 1'b0 || obs_rst_done !== 1'b0) begin nerr++; $display("FAIL midreset_run got ro_en=%b done=%b exp=0,0", obs_rst_ro, obs_rst_done); end
      nvec++; if (obs_done_cnt != 0) begin nerr++; $display("FAIL midreset_run_no_done got=%0d exp=0", obs_done_cnt); end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < NB; k++) begin plan_a[k] = 8'($urandom); plan_b[k] = 8'($urandom); end
      do_run(5'd17, 1'b1, -1, -1, LAT + 2);
      nvec++; if (obs_done_cyc != LAT) begin nerr++; $display("FAIL b2b_latency got=%0d exp=%0d", obs_done_cyc, LAT); end
      nvec++; if (obs_resp !== model_resp()) begin nerr++; $display("FAIL b2b_response got=%b exp=%b", obs_resp, model_resp()); end
      nvec++; if (obs_after_busy !== 1'b0) begin nerr++; $display("FAIL b2b_idle_cycle got=%b exp=0", obs_after_busy); end
      nvec++; if (obs_after2_busy !== 1'b1 || obs_after2_clr !== 1'b1) begin nerr++; $display("FAIL b2b_retrigger got busy=%b clr=%b exp=1,1", obs_after2_busy, obs_after2_clr); end
      pulse_reset();
   endtask

   task automatic test_saturate();
      int done_cyc, done_cnt;
      logic [3:0] t;
      logic [NB2-1:0] r;
      done_cyc = -1; done_cnt = 0; t = 4'd0; r = '1;
      @(negedge clk);
      challenge_base2 = 5'd7;
      start2 = 1'b1;
      for (int cyc = 1; cyc <= LAT2 + 4; cyc++) begin
         @(negedge clk);
         start2 = 1'b0;
         if (done2) begin
            done_cnt++;
            if (done_cyc < 0) begin done_cyc = cyc; t = ties2; r = response2; end
         end
      end
      nvec++; if (done_cyc != LAT2) begin nerr++; $display("FAIL sat_latency got=%0d exp=%0d", done_cyc, LAT2); end
      nvec++; if (done_cnt != 1) begin nerr++; $display("FAIL sat_done_count got=%0d exp=1", done_cnt); end
      nvec++; if (t !== 4'd15) begin nerr++; $display("FAIL sat_ties got=%0d exp=15", t); end
      nvec++; if (r !== '0) begin nerr++; $display("FAIL sat_response got=%h exp=0", r); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_pattern();
      test_wrap();
      test_ties();
      test_timing();
      test_start_ignored();
      test_reset_mid();
      test_back_to_back();
      test_saturate();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
